// File: rtl/coef_collector.sv
// Packs one subgraph's per-edge coefficients into a wide softmax word and counts subgraphs per layer.
// Optional running-max output enabled by defining COEF_COLLECT_MAX_EN.
//   state     | meaning
//   S_IDLE    | wait for a node count; pop it and latch the (saturated) count
//   S_COLLECT | pop coefficients into consecutive slots until count reached
//   S_WRITE   | present packed word; write when softmax FIFO not full
module coef_collector #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_NODES      = 168,
  parameter int NUM_SUBGRAPHS  = 2708,
  parameter int NUM_NODE_WIDTH = $clog2(MAX_NODES),
  parameter int SOFTMAX_WIDTH  = MAX_NODES*DATA_WIDTH+NUM_NODE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     coef_ff_dout,
  input  logic                      coef_ff_empty,
  output logic                      coef_ff_rd_vld,
  input  logic [NUM_NODE_WIDTH-1:0] nn_ff_dout,
  input  logic                      nn_ff_empty,
  output logic                      nn_ff_rd_vld,
  output logic [SOFTMAX_WIDTH-1:0]  sm_ff_din,
  input  logic                      sm_ff_full,
  output logic                      sm_ff_wr_vld,
`ifdef COEF_COLLECT_MAX_EN
  output logic [DATA_WIDTH-1:0]     coef_max_o,
  output logic                      coef_max_vld_o,
`endif
  output logic                      collect_done_o,
  output logic                      nn_err_o
);

  localparam int SUB_W = $clog2(NUM_SUBGRAPHS+1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE} state_e;

  state_e                    state_q;
  logic [NUM_NODE_WIDTH-1:0] num_node_q;
  logic [NUM_NODE_WIDTH-1:0] idx_q;
  logic [SOFTMAX_WIDTH-1:0]  pack_q;
  logic [SOFTMAX_WIDTH-1:0]  pack_ins;
  logic [SUB_W-1:0]          sub_cnt_q;
  logic                      done_q;
  logic                      err_q;
  logic                      nn_over;
  logic [NUM_NODE_WIDTH-1:0] nn_sat;

  // Gating with rst_n keeps the pop strobe low while reset is held.
  assign nn_ff_rd_vld   = rst_n && (state_q == S_IDLE) && !nn_ff_empty && !done_q;
  assign coef_ff_rd_vld = (state_q == S_COLLECT) && !coef_ff_empty;
  assign sm_ff_wr_vld   = (state_q == S_WRITE) && !sm_ff_full;

  assign nn_over = nn_ff_dout > NUM_NODE_WIDTH'(MAX_NODES);
  assign nn_sat  = nn_over ? NUM_NODE_WIDTH'(MAX_NODES) : nn_ff_dout;

  assign sm_ff_din      = pack_q;
  assign collect_done_o = done_q;
  assign nn_err_o       = err_q;

  // Slot 0 sits at the MSB; decode the slot index against constant positions.
  always_comb begin
    pack_ins = pack_q;
    for (int j = 0; j < MAX_NODES; j++) begin
      if (idx_q == NUM_NODE_WIDTH'(j)) begin
        pack_ins[SOFTMAX_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH] = coef_ff_dout;
      end
    end
  end

`ifdef COEF_COLLECT_MAX_EN
  logic [DATA_WIDTH-1:0] max_q;
  assign coef_max_o     = max_q;
  assign coef_max_vld_o = sm_ff_wr_vld;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      num_node_q <= '0;
      idx_q      <= '0;
      pack_q     <= '0;
      sub_cnt_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef COEF_COLLECT_MAX_EN
      max_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (nn_ff_rd_vld) begin
            num_node_q                   <= nn_sat;
            pack_q[NUM_NODE_WIDTH-1:0]   <= nn_sat;
            idx_q                        <= '0;
            if (nn_over) err_q <= 1'b1;
`ifdef COEF_COLLECT_MAX_EN
            max_q <= '0;
`endif
            state_q <= (nn_sat == '0) ? S_WRITE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (coef_ff_rd_vld) begin
            pack_q <= pack_ins;
            idx_q  <= idx_q + 1'b1;
`ifdef COEF_COLLECT_MAX_EN
            if (coef_ff_dout > max_q) max_q <= coef_ff_dout;
`endif
            if ((idx_q + 1'b1) == num_node_q) state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (sm_ff_wr_vld) begin
            sub_cnt_q <= sub_cnt_q + 1'b1;
            if (sub_cnt_q == SUB_W'(NUM_SUBGRAPHS-1)) done_q <= 1'b1;
            pack_q  <= '0;
            idx_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coef_collector.sv
// Scoreboard bench for coef_collector: queue-modelled FIFOs, randomized traffic, expected words
// computed from the packing rules; checks running max when COEF_COLLECT_MAX_EN is defined.
module tb_coef_collector;
  localparam int DW   = 8;
  localparam int MAXN = 168;
  localparam int NSG  = 4;
  localparam int NNW  = $clog2(MAXN);
  localparam int SW   = MAXN*DW+NNW;

  typedef logic [7:0] bq_t [$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] coef_ff_dout = '0;
  logic          coef_ff_empty = 1'b1;
  logic          coef_ff_rd_vld;
  logic [NNW-1:0] nn_ff_dout = '0;
  logic          nn_ff_empty = 1'b1;
  logic          nn_ff_rd_vld;
  logic [SW-1:0] sm_ff_din;
  logic          sm_ff_full = 1'b0;
  logic          sm_ff_wr_vld;
  logic          collect_done_o;
  logic          nn_err_o;
`ifdef COEF_COLLECT_MAX_EN
  logic [DW-1:0] coef_max_o;
  logic          coef_max_vld_o;
`endif

  coef_collector #(.NUM_SUBGRAPHS(NSG)) dut (
    .clk(clk), .rst_n(rst_n),
    .coef_ff_dout(coef_ff_dout), .coef_ff_empty(coef_ff_empty), .coef_ff_rd_vld(coef_ff_rd_vld),
    .nn_ff_dout(nn_ff_dout), .nn_ff_empty(nn_ff_empty), .nn_ff_rd_vld(nn_ff_rd_vld),
    .sm_ff_din(sm_ff_din), .sm_ff_full(sm_ff_full), .sm_ff_wr_vld(sm_ff_wr_vld),
`ifdef COEF_COLLECT_MAX_EN
    .coef_max_o(coef_max_o), .coef_max_vld_o(coef_max_vld_o),
`endif
    .collect_done_o(collect_done_o), .nn_err_o(nn_err_o)
  );

  always #5 clk = ~clk;

  logic [7:0]    coef_q [$];
  int            nn_q [$];
  logic [SW-1:0] exp_q [$];
  logic [7:0]    expmax_q [$];

  int  n_cmp = 0, n_bad = 0, cyc = 0;
  bit  pop_coef = 0, pop_nn = 0, pending = 0, err_m = 0;
  int  wr_due = 0, rem = 0, wr_cnt = 0;
  bit  full_force = 0, rand_full = 0, rand_stall = 0, coef_hold = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_word(string nm, logic [SW-1:0] act, logic [SW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual field=%0d top64=%h required field=%0d top64=%h (cycle %0d)",
               nm, act[NNW-1:0], act[SW-1 -: 64], exp[NNW-1:0], exp[SW-1 -: 64], cyc);
    end
  endtask

  // FIFO models: pops decided at the previous negedge are applied just after the edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pop_coef && coef_q.size() > 0) void'(coef_q.pop_front());
      if (pop_nn && nn_q.size() > 0) void'(nn_q.pop_front());
      pop_coef = 0; pop_nn = 0;
      coef_ff_empty = (coef_q.size() == 0) || coef_hold || (rand_stall && $urandom_range(0, 3) == 0);
      coef_ff_dout  = (coef_q.size() > 0) ? coef_q[0] : '0;
      nn_ff_empty   = (nn_q.size() == 0);
      nn_ff_dout    = (nn_q.size() > 0) ? NNW'(nn_q[0]) : '0;
      sm_ff_full    = full_force || (rand_full && $urandom_range(0, 2) == 0);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [SW-1:0] e;
    logic [7:0]    em;
    int            n;
    if (rst_n) begin
      chk("collect_done", collect_done_o, (wr_cnt >= NSG));
      chk("nn_err", nn_err_o, err_m);
      if (coef_ff_rd_vld) chk("coef_pop_while_empty", coef_ff_empty, 0);
      if (nn_ff_rd_vld)   chk("nn_pop_while_empty", nn_ff_empty, 0);
      if (sm_ff_wr_vld)   chk("write_while_full", sm_ff_full, 0);
      if (collect_done_o) chk("nn_pop_after_done", nn_ff_rd_vld, 0);
      pop_coef = coef_ff_rd_vld;
      pop_nn   = nn_ff_rd_vld;
      if (sm_ff_wr_vld) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          em = expmax_q.pop_front();
          chk_word("word", sm_ff_din, e);
          chk("write_timing", (pending && cyc == wr_due), 1);
`ifdef COEF_COLLECT_MAX_EN
          chk("coef_max", coef_max_o, em);
          chk("coef_max_vld", coef_max_vld_o, 1);
`endif
        end
        pending = 0;
        wr_cnt++;
      end else if (pending && cyc == wr_due) begin
        if (sm_ff_full) begin
          if (exp_q.size() > 0) chk_word("din_stable_under_full", sm_ff_din, exp_q[0]);
          wr_due++;
        end else begin
          chk("write_missing", 0, 1);
          pending = 0;
        end
      end
      if (nn_ff_rd_vld && nn_q.size() > 0) begin
        n = nn_q[0];
        if (n > MAXN) err_m = 1;
        rem = (n > MAXN) ? MAXN : n;
        if (rem == 0) begin pending = 1; wr_due = cyc + 1; end
      end
      if (coef_ff_rd_vld) begin
        chk("coef_overpop", (rem > 0), 1);
        rem--;
        if (rem == 0) begin pending = 1; wr_due = cyc + 1; end
      end
    end
  end

  task automatic add_sub(input int n, input bq_t c, input bit push_coefs);
    logic [SW-1:0] w;
    logic [7:0]    mx;
    int            ne;
    ne = (n > MAXN) ? MAXN : n;
    w  = '0;
    mx = '0;
    for (int j = 0; j < ne; j++) begin
      w[SW-1-DW*j -: DW] = c[j];
      if (c[j] > mx) mx = c[j];
    end
    w[NNW-1:0] = NNW'(ne);
    nn_q.push_back(n);
    exp_q.push_back(w);
    expmax_q.push_back(mx);
    if (push_coefs) foreach (c[j]) coef_q.push_back(c[j]);
  endtask

  task automatic rand_coefs(input int n, output bq_t c);
    c = {};
    for (int j = 0; j < n; j++) c.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 0;
    coef_q.delete(); nn_q.delete(); exp_q.delete(); expmax_q.delete();
    pop_coef = 0; pop_nn = 0; pending = 0; rem = 0; wr_cnt = 0; err_m = 0;
    full_force = 0; rand_full = 0; rand_stall = 0; coef_hold = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_word("rst_din", sm_ff_din, '0);
    chk("rst_wr_vld", sm_ff_wr_vld, 0);
    chk("rst_coef_rd", coef_ff_rd_vld, 0);
    chk("rst_nn_rd", nn_ff_rd_vld, 0);
    chk("rst_done", collect_done_o, 0);
    chk("rst_err", nn_err_o, 0);
    @(negedge clk); #1;
    rst_n = 1;
  endtask

  task automatic wait_writes(input int target, input int budget);
    int k;
    k = 0;
    while (wr_cnt < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (wr_cnt < target) chk("write_timeout", wr_cnt, target);
  endtask

  initial begin
    bq_t c;
    int  n;
    do_reset();

    // basic
    c = {8'h11, 8'h22, 8'h33};
    add_sub(3, c, 1);
    wait_writes(1, 50);

    // backpressure held across the write window
    full_force = 1;
    add_sub(3, c, 1);
    repeat (12) @(posedge clk);
    #1 full_force = 0;
    wait_writes(2, 50);

    // starvation mid-subgraph
    c = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    add_sub(4, c, 0);
    coef_q.push_back(c[0]); coef_q.push_back(c[1]);
    repeat (12) @(posedge clk);
    #1;
    chk("starve_rem", rem, 2);
    coef_q.push_back(c[2]); coef_q.push_back(c[3]);
    wait_writes(3, 50);

    // zero count and overflow
    do_reset();
    c = {};
    add_sub(0, c, 1);
    rand_coefs(200, c);
    add_sub(200, c, 1);
    wait_writes(2, 400);
    repeat (3) @(posedge clk);
    #1;
    chk("overflow_left_in_fifo", coef_q.size(), 32);
    chk("overflow_err", nn_err_o, 1);
    coef_q.delete();
    c = {8'h42};
    add_sub(1, c, 1);
    wait_writes(3, 50);
    chk("nn_err_sticky", nn_err_o, 1);

    // completion: NSG writes, then an extra entry stays unpopped
    do_reset();
    for (int s = 0; s < NSG; s++) begin
      rand_coefs(2, c);
      add_sub(2, c, 1);
    end
    nn_q.push_back(2);
    wait_writes(NSG, 100);
    repeat (6) @(posedge clk);
    #1;
    chk("done_after_last", collect_done_o, 1);
    chk("extra_nn_not_popped", nn_q.size(), 1);

    // randomized rounds with random stalls and backpressure
    for (int r = 0; r < 6; r++) begin
      do_reset();
      rand_full = 1; rand_stall = 1;
      for (int s = 0; s < NSG; s++) begin
        n = ($urandom_range(0, 7) == 0) ? $urandom_range(169, 255) : $urandom_range(0, 40);
        rand_coefs((n > MAXN) ? MAXN : n, c);
        add_sub(n, c, 1);
      end
      wait_writes(NSG, 3000);
      repeat (4) @(posedge clk);
      #1;
      chk("rand_done", collect_done_o, 1);
      chk("rand_coef_fifo_drained", coef_q.size(), 0);
    end

    // reset in the middle of a subgraph
    do_reset();
    c = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    add_sub(5, c, 0);
    coef_q.push_back(c[0]); coef_q.push_back(c[1]);
    for (int k = 0; k < 30 && rem != 3; k++) begin
      @(posedge clk); #1;
    end
    chk("midreset_two_popped", rem, 3);
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    chk("midreset_no_write", wr_cnt, 0);
    c = {8'd5, 8'd9, 8'd3};
    add_sub(3, c, 1);
    wait_writes(1, 50);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/coef_collector.md
Name: coef_collector

Overview:
- Downstream neighbour of the attention-coefficient (DMVM) stage.
- Pops the per-edge 8-bit coefficients that DMVM pushes into the coefficient FIFO, and pops the matching per-subgraph node count from a num_node FIFO.
- Packs one subgraph's coefficients into a single wide softmax word and writes it to the softmax FIFO.
- Counts subgraphs and flags completion of a layer.

Parameters:
- DATA_WIDTH, 8, coefficient width.
- MAX_NODES, 168, maximum nodes (coefficients) per subgraph.
- NUM_SUBGRAPHS, 2708, subgraphs per layer.
- NUM_NODE_WIDTH, $clog2(MAX_NODES), width of the node-count field.
- SOFTMAX_WIDTH, MAX_NODES*DATA_WIDTH+NUM_NODE_WIDTH, packed output word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- coef_ff_dout  in  DATA_WIDTH  coefficient FIFO head (first-word-fall-through).
- coef_ff_empty  in  1  coefficient FIFO empty.
- coef_ff_rd_vld  out  1  pop coefficient FIFO this cycle.
- nn_ff_dout  in  NUM_NODE_WIDTH  node-count FIFO head (FWFT).
- nn_ff_empty  in  1  node-count FIFO empty.
- nn_ff_rd_vld  out  1  pop node-count FIFO this cycle.
- sm_ff_din  out  SOFTMAX_WIDTH  packed softmax word.
- sm_ff_full  in  1  softmax FIFO full.
- sm_ff_wr_vld  out  1  write softmax FIFO this cycle.
- collect_done_o  out  1  high after the last subgraph is written; cleared by reset only.
- nn_err_o  out  1  sticky: a node count > MAX_NODES was seen.

Behaviour:
- Single clock clk; reset asynchronous, active-low (rst_n).
- Reset values:
  - all outputs 0;
  - packing register 0, slot index 0, subgraph counter 0;
  - state IDLE.
- FSM states and transitions:
  - IDLE: if !nn_ff_empty && !collect_done_o → nn_ff_rd_vld=1 (same cycle); latch count into num_node_reg; → COLLECT, or → WRITE if count==0.
  - COLLECT: coef_ff_rd_vld = !coef_ff_empty (combinational). Each pop stores coef_ff_dout into slot idx and increments idx. The pop making idx==num_node_reg → WRITE. Empty FIFO: stall, no pop, state held.
  - WRITE: sm_ff_wr_vld = !sm_ff_full (combinational). On write: increment subgraph counter; clear packing register and idx; → IDLE. If the counter reaches NUM_SUBGRAPHS, set collect_done_o in the same edge.
- Packing format:
  - coefficient j occupies sm_ff_din[SOFTMAX_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH] (slot 0 at the MSB);
  - sm_ff_din[NUM_NODE_WIDTH-1:0] = num_node_reg;
  - unused slots are zero.
- sm_ff_din is registered and holds stable while full stalls the write.
- Count > MAX_NODES: saturate num_node_reg to MAX_NODES; set nn_err_o. Excess coefficients are not popped.
- At most one coefficient pop per cycle.
- Latency: last coefficient pop → sm_ff_wr_vld high the next cycle (if not full). A count of 0 writes 1 cycle after the nn pop.
- Throughput: num_node+2 cycles per subgraph with no stalls.
- rd/wr strobes never assert while the corresponding empty/full is high.
- After collect_done_o, no further nn pops.
- Reset mid-operation: partial vector discarded, FSM to IDLE, no write.

Optional Feature:
- Macro COEF_COLLECT_MAX_EN.
- Defined:
  - adds output port coef_max_o (DATA_WIDTH) and coef_max_vld_o (1);
  - tracks the unsigned running max of popped coefficients for the current subgraph, reset to 0 at IDLE→COLLECT;
  - coef_max_o is valid, with coef_max_vld_o=1, in the same cycle as sm_ff_wr_vld;
  - for a count of 0, coef_max_o=0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Basic: nn=3, coefs 0x11,0x22,0x33, FIFOs never empty/full → one write. Top 24 bits of sm_ff_din = 0x112233, remaining slots 0, low field = 3. Write occurs 1 cycle after the 3rd pop.
- Backpressure: as basic, with sm_ff_full high 5 cycles during WRITE → sm_ff_wr_vld stays 0 for those 5 cycles, din stable, single write when full drops.
- Starvation: nn=4 with coef FIFO going empty after 2 coefs for 10 cycles → no pops while empty; the output word is correct once coefs 3–4 arrive.
- Zero/overflow: nn=0 → word all-zero slots, field 0, no coef pops. nn=200 → 168 coefs popped, field=168, nn_err_o=1 and sticky.
- Completion: NUM_SUBGRAPHS=4 override, 4 subgraphs with nn=2 → exactly 4 writes. collect_done_o rises on the 4th write; a 5th nn entry is not popped.
- Reset mid-COLLECT after 2 of 5 coefs → outputs 0, no write. The next subgraph packs from slot 0. With COEF_COLLECT_MAX_EN: coefs 5,9,3 give coef_max_o=9 in the write cycle.
